display_scan_ctrl: RTL
======================

# display_scan_ctrl

Time-multiplexing scan controller for the 3-digit common-anode 7-segment display. It takes three BCD digits from the counter logic and drives the shared SEG bus and the DIGIT enables one digit at a time. Per-slot behaviour: anti-ghosting blank gap, 16-level PWM brightness, leading-zero suppression and decimal points. Inputs are snapshotted once per frame, so a count changing mid-scan never tears the display.

## Interface
Parameters:
- SLOT_LOG2, 14: one digit slot lasts 2^SLOT_LOG2 CLK cycles. Must be ≥ 5.
- BLANK_CYCLES, 200: cycles at the start of each slot with all digits off. Must be < 2^(SLOT_LOG2-4).

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  system clock; all state on the rising edge
- RST  in  1  asynchronous, active-high reset
- units  in  4  BCD digit 0
- tens  in  4  BCD digit 1
- hundreds  in  4  BCD digit 2
- dp  in  3  decimal point request per digit; bit i maps to digit i
- lz_en  in  1  leading-zero suppression enable
- brightness  in  4  0 = dimmest (1/16 of slot), 15 = full
- blank  in  1  forces the display dark
- SEG  out  8  active-low segments; bit0=a … bit6=g, bit7=dp
- DIGIT  out  3  active-low digit enables; bit0=units, bit1=tens, bit2=hundreds
- frame_strobe  out  1  one-cycle pulse at the start of each frame

## Operation
- Slot counter cnt has SLOT_LOG2 bits and free-runs 0 … 2^SLOT_LOG2−1, then wraps to 0.
- On each wrap, digit index idx advances 0→1→2→0. Scan order is units, tens, hundreds.
- Per-slot FSM:
  - BLANK: while cnt < BLANK_CYCLES. DIGIT=111, SEG=FF.
  - ON: while cnt ≥ BLANK_CYCLES and cnt[SLOT_LOG2-1:SLOT_LOG2-4] ≤ brightness. DIGIT[idx]=0, SEG = decoded glyph.
  - OFF: remainder of the slot. DIGIT=111, SEG=FF.
  - On cnt wrap, the FSM always returns to BLANK.
- Snapshot: when cnt==0 and idx==0, units, tens, hundreds, dp and lz_en are registered. All three slots of that frame display the snapshot. brightness and blank are live.
- Decode (active-low, dp off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Values 10–15 show a dash (BF).
- When dp[idx] is set, SEG[7]=0.
- Leading-zero suppression, when the snapshot lz_en=1:
  - hundreds is blank if hundreds==0.
  - tens is blank if hundreds==0 and tens==0.
  - units is never suppressed.
  - A suppressed digit keeps DIGIT high and SEG=FF for its whole slot, including its dp.
  - Invalid BCD (10–15) counts as nonzero.
- blank=1 forces DIGIT=111 and SEG=FF. Counters and FSM keep running.
- frame_strobe: asserted for the cycle in which the snapshot is taken.
- At most one DIGIT bit is ever low.
- SEG is FF whenever DIGIT is 111.

## Timing
- Reset (async assert, synchronous release by the system): cnt=0, idx=0, FSM=BLANK, snapshot=0, SEG=FF, DIGIT=111, frame_strobe=0.
- All outputs are registered and show the decision made from the cnt/idx value of the previous cycle (1-cycle latency).
- The first edge after reset release takes a snapshot. frame_strobe goes high one cycle later.
- With BLANK_CYCLES=B, a digit turns on (output) at cycle B+1 of its slot, and turns off one cycle after the last ON count.
- ON duration per slot = (brightness+1)·2^(SLOT_LOG2-4) − B cycles.
- Frame period = 3·2^SLOT_LOG2 cycles.
- A change of brightness or blank takes effect on outputs 1 cycle later.
- A change of BCD inputs takes effect at the next frame start, worst case 3·2^SLOT_LOG2 cycles.
- RST asserted mid-slot immediately (asynchronously) forces SEG=FF and DIGIT=111, and restarts at slot 0.

## Test plan
All scenarios use SLOT_LOG2=6, BLANK_CYCLES=2.
- Reset mid-slot: RST pulses at cycle 37 → SEG=FF and DIGIT=111 the same instant. After release, frame_strobe pulses once; the next pulse is 192 cycles later.
- Digit scan: inputs 1/7/5, brightness=15, lz_en=0. Expected:
  - units slot: DIGIT=110, SEG=F9 for 62 cycles.
  - tens slot: DIGIT=101, SEG=F8.
  - hundreds slot: DIGIT=011, SEG=92.
  - Each slot is preceded by 2 dark cycles, and no two DIGIT bits are ever low together.
- Brightness: brightness=3 → 14 lit cycles per slot. brightness=0 → 2 lit cycles.
- Leading zeros and dp: inputs hundreds=0, tens=0, units=0, lz_en=1 → only units lit (C0). hundreds=0, tens=4, units=0, dp=010 → tens shows 19 (4 with dp), hundreds dark.
- Snapshot and invalid input: change units 3→8 during the tens slot → units still shows B0 until the next frame_strobe, then 80. Then units=12 → BF.
- blank=1 for 20 cycles during an ON phase → outputs dark 1 cycle later and restored 1 cycle after release. Slot and frame timing are unchanged.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a 3-digit common-anode 7-segment display:
// blank gap, 16-level PWM, leading-zero suppression, decimal points, per-frame input snapshot.
module display_scan_ctrl #(
    parameter int SLOT_LOG2    = 14,
    parameter int BLANK_CYCLES = 200
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] units,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [2:0] dp,
    input  logic       lz_en,
    input  logic [3:0] brightness,
    input  logic       blank,
    output logic [7:0] SEG,
    output logic [2:0] DIGIT,
    output logic       frame_strobe
);

    typedef enum logic [1:0] {
        ST_BLANK,
        ST_ON,
        ST_OFF
    } state_t;

    localparam logic [SLOT_LOG2-1:0] BLANK_END = SLOT_LOG2'(BLANK_CYCLES);

    logic [SLOT_LOG2-1:0] cnt;
    logic [1:0]           idx;
    state_t               state;
    state_t               state_next;

    logic [3:0] snap_units;
    logic [3:0] snap_tens;
    logic [3:0] snap_hundreds;
    logic [2:0] snap_dp;
    logic       snap_lz;

    logic [3:0] v_units;
    logic [3:0] v_tens;
    logic [3:0] v_hundreds;
    logic [2:0] v_dp;
    logic       v_lz;

    logic       frame_start;
    logic       in_blank;
    logic       in_window;
    logic [3:0] cur_digit;
    logic       cur_dp;
    logic [2:0] digit_on;
    logic       suppress;
    logic [7:0] seg_next;
    logic [2:0] digit_next;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0:    glyph = 7'h40;
            4'd1:    glyph = 7'h79;
            4'd2:    glyph = 7'h24;
            4'd3:    glyph = 7'h30;
            4'd4:    glyph = 7'h19;
            4'd5:    glyph = 7'h12;
            4'd6:    glyph = 7'h02;
            4'd7:    glyph = 7'h78;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h10;
            default: glyph = 7'h3F;
        endcase
    endfunction

    assign frame_start = (cnt == '0) && (idx == 2'd0);
    assign in_blank    = (cnt < BLANK_END);
    assign in_window   = (cnt[SLOT_LOG2-1 -: 4] <= brightness);

    // The snapshot edge itself already sees the new inputs, so a zero-length blank gap stays coherent.
    assign v_units    = frame_start ? units    : snap_units;
    assign v_tens     = frame_start ? tens     : snap_tens;
    assign v_hundreds = frame_start ? hundreds : snap_hundreds;
    assign v_dp       = frame_start ? dp       : snap_dp;
    assign v_lz       = frame_start ? lz_en    : snap_lz;

    always_comb begin
        cur_digit = v_units;
        cur_dp    = v_dp[0];
        digit_on  = 3'b110;
        suppress  = 1'b0;
        case (idx)
            2'd1: begin
                cur_digit = v_tens;
                cur_dp    = v_dp[1];
                digit_on  = 3'b101;
                suppress  = v_lz && (v_hundreds == 4'd0) && (v_tens == 4'd0);
            end
            2'd2: begin
                cur_digit = v_hundreds;
                cur_dp    = v_dp[2];
                digit_on  = 3'b011;
                suppress  = v_lz && (v_hundreds == 4'd0);
            end
            default: begin
            end
        endcase
    end

    // Phase for the current count; brightness is live so ON and OFF may alternate mid-slot.
    always_comb begin
        state_next = state;
        case (state)
            ST_BLANK: if (!in_blank) state_next = in_window ? ST_ON : ST_OFF;
            ST_ON: begin
                if (in_blank)        state_next = ST_BLANK;
                else if (!in_window) state_next = ST_OFF;
            end
            ST_OFF: begin
                if (in_blank)       state_next = ST_BLANK;
                else if (in_window) state_next = ST_ON;
            end
            default: state_next = ST_BLANK;
        endcase

        seg_next   = 8'hFF;
        digit_next = 3'b111;
        if ((state_next == ST_ON) && !blank && !suppress) begin
            seg_next   = {~cur_dp, glyph(cur_digit)};
            digit_next = digit_on;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt           <= '0;
            idx           <= 2'd0;
            state         <= ST_BLANK;
            SEG           <= 8'hFF;
            DIGIT         <= 3'b111;
            frame_strobe  <= 1'b0;
            snap_units    <= 4'd0;
            snap_tens     <= 4'd0;
            snap_hundreds <= 4'd0;
            snap_dp       <= 3'd0;
            snap_lz       <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            if (cnt == '1)
                idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            state        <= state_next;
            SEG          <= seg_next;
            DIGIT        <= digit_next;
            frame_strobe <= frame_start;
            if (frame_start) begin
                snap_units    <= units;
                snap_tens     <= tens;
                snap_hundreds <= hundreds;
                snap_dp       <= dp;
                snap_lz       <= lz_en;
            end
        end
    end

endmodule
